time_keeper: RTL and testbench

Timekeeping core directly downstream of the button controller. It consumes `clk_mode`, `timer_mode` and the `vButton` pulses and levels, and maintains the hours:minutes:seconds time-of-day counters plus an alarm time. It also raises the alarm ring and drives registered display values in 24h or 12h format toward the display driver.

---
 rtl/time_keeper.sv | 162 ++++++++++++++++
 tb/tb_time_keeper.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// time_keeper: time-of-day and alarm counters, alarm ring control and
// registered 24h/12h display values for the downstream display driver.
module time_keeper #(
    parameter int unsigned MFREQ_KHZ    = 1,
    parameter int unsigned RING_SECONDS = 60
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [1:0] clk_mode,
    input  logic [1:0] timer_mode,
    input  logic [5:0] vButton,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       tick_1hz,
    output logic       alarm_ring,
    output logic [4:0] disp_hours,
    output logic [5:0] disp_minutes,
    output logic [5:0] disp_seconds,
    output logic       disp_pm
);

    localparam int unsigned PRESC_W = 32;
    localparam int unsigned DIV     = MFREQ_KHZ * 1000;
    localparam int unsigned RING_W  = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;

    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;

    logic [PRESC_W-1:0] presc;
    logic [RING_W-1:0]  ring_cnt;

    logic       set_time_c;
    logic       set_alarm_c;
    logic       btn_en_c;
    logic       tick_c;
    logic       trig_c;
    logic       cancel_c;
    logic [4:0] hours_nx_c;
    logic [5:0] minutes_nx_c;
    logic [5:0] seconds_nx_c;
    logic [4:0] src_hours_c;
    logic [5:0] src_minutes_c;
    logic [5:0] src_seconds_c;
    logic [4:0] disp_hours_c;
    logic       disp_pm_c;

    // vButton[5] carries nothing for this block.
    logic unused_vbutton;
    assign unused_vbutton = vButton[5];

    // Mode decode, second tick, next time-of-day and alarm trigger/cancel.
    always_comb begin
        set_time_c   = (clk_mode == MODE_SET_TIME);
        set_alarm_c  = (clk_mode == MODE_SET_ALARM);
        btn_en_c     = (timer_mode == 2'd0);
        tick_c       = !set_time_c && (presc == PRESC_W'(DIV - 1));
        hours_nx_c   = hours;
        minutes_nx_c = minutes;
        seconds_nx_c = seconds;

        if (tick_c) begin
            if (seconds == 6'd59) begin
                seconds_nx_c = '0;
                if (minutes == 6'd59) begin
                    minutes_nx_c = '0;
                    hours_nx_c   = (hours == 5'd23) ? '0 : hours + 5'd1;
                end else begin
                    minutes_nx_c = minutes + 6'd1;
                end
            end else begin
                seconds_nx_c = seconds + 6'd1;
            end
        end

        // The prescaler is held in set-time mode, so no tick competes here.
        if (set_time_c && btn_en_c) begin
            if (vButton[0]) minutes_nx_c = (minutes == 6'd59) ? '0 : minutes + 6'd1;
            if (vButton[1]) hours_nx_c   = (hours == 5'd23) ? '0 : hours + 5'd1;
            if (vButton[2]) seconds_nx_c = '0;
        end

        trig_c   = tick_c && vButton[4] && !set_time_c &&
                   (hours_nx_c == alarm_hours) && (minutes_nx_c == alarm_minutes) &&
                   (seconds_nx_c == 6'd0);
        cancel_c = !vButton[4] || set_time_c;
    end

    // Prescaler, time counters, alarm registers and ring state.
    always_ff @(posedge mclk) begin
        if (rst) begin
            presc         <= '0;
            tick_1hz      <= 1'b0;
            hours         <= '0;
            minutes       <= '0;
            seconds       <= '0;
            alarm_hours   <= '0;
            alarm_minutes <= '0;
            alarm_ring    <= 1'b0;
            ring_cnt      <= '0;
        end else begin
            presc    <= (set_time_c || tick_c) ? '0 : presc + PRESC_W'(1);
            tick_1hz <= tick_c;
            hours    <= hours_nx_c;
            minutes  <= minutes_nx_c;
            seconds  <= seconds_nx_c;

            if (set_alarm_c && btn_en_c) begin
                if (vButton[0]) alarm_minutes <= (alarm_minutes == 6'd59) ? '0 : alarm_minutes + 6'd1;
                if (vButton[1]) alarm_hours   <= (alarm_hours == 5'd23) ? '0 : alarm_hours + 5'd1;
            end

            if (cancel_c) begin
                alarm_ring <= 1'b0;
            end else if (trig_c) begin
                alarm_ring <= 1'b1;
                ring_cnt   <= '0;
            end else if (alarm_ring && tick_c) begin
                if (ring_cnt == RING_W'(RING_SECONDS - 1)) begin
                    alarm_ring <= 1'b0;
                end else begin
                    ring_cnt <= ring_cnt + RING_W'(1);
                end
            end
        end
    end

    // Display source selection and 12h conversion.
    always_comb begin
        src_hours_c   = set_alarm_c ? alarm_hours : hours;
        src_minutes_c = set_alarm_c ? alarm_minutes : minutes;
        src_seconds_c = set_alarm_c ? 6'd0 : seconds;
        disp_hours_c  = src_hours_c;
        disp_pm_c     = 1'b0;
        if (vButton[3]) begin
            disp_pm_c = (src_hours_c >= 5'd12);
            if (src_hours_c == 5'd0) begin
                disp_hours_c = 5'd12;
            end else if (src_hours_c > 5'd12) begin
                disp_hours_c = src_hours_c - 5'd12;
            end
        end
    end

    // Display registers, one cycle behind the counters.
    always_ff @(posedge mclk) begin
        if (rst) begin
            disp_hours   <= '0;
            disp_minutes <= '0;
            disp_seconds <= '0;
            disp_pm      <= 1'b0;
        end else begin
            disp_hours   <= disp_hours_c;
            disp_minutes <= src_minutes_c;
            disp_seconds <= src_seconds_c;
            disp_pm      <= disp_pm_c;
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: four time_keeper instances on one clock. Instance 0 is
// checked every cycle against a behavioural model; instances 1..3 share its
// inputs but have private reset / alarm-enable so one rollover can exercise
// ring cancel, reset mid-ring and the disabled-alarm case in parallel.
module tb_time_keeper;

    localparam int unsigned MFREQ_KHZ = 1;
    localparam int DIV   = MFREQ_KHZ * 1000;
    localparam int NDUT  = 4;
    localparam int RING0 = 4;

    logic            mclk = 1'b0;
    logic [NDUT-1:0] rst;
    logic [1:0]      clk_mode;
    logic [1:0]      timer_mode;
    logic [3:0]      btn;
    logic [NDUT-1:0] alarm_en;
    logic            vb5;

    logic [4:0] hours         [NDUT];
    logic [5:0] minutes       [NDUT];
    logic [5:0] seconds       [NDUT];
    logic [4:0] alarm_hours   [NDUT];
    logic [5:0] alarm_minutes [NDUT];
    logic       tick_1hz      [NDUT];
    logic       alarm_ring    [NDUT];
    logic [4:0] disp_hours    [NDUT];
    logic [5:0] disp_minutes  [NDUT];
    logic [5:0] disp_seconds  [NDUT];
    logic       disp_pm       [NDUT];

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;
    int cur_h = 0;

    always #5 mclk = ~mclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        time_keeper #(
            .MFREQ_KHZ   (MFREQ_KHZ),
            .RING_SECONDS((g == 0) ? RING0 : 60)
        ) u_dut (
            .mclk         (mclk),
            .rst          (rst[g]),
            .clk_mode     (clk_mode),
            .timer_mode   (timer_mode),
            .vButton      ({vb5, alarm_en[g], btn}),
            .hours        (hours[g]),
            .minutes      (minutes[g]),
            .seconds      (seconds[g]),
            .alarm_hours  (alarm_hours[g]),
            .alarm_minutes(alarm_minutes[g]),
            .tick_1hz     (tick_1hz[g]),
            .alarm_ring   (alarm_ring[g]),
            .disp_hours   (disp_hours[g]),
            .disp_minutes (disp_minutes[g]),
            .disp_seconds (disp_seconds[g]),
            .disp_pm      (disp_pm[g])
        );
    end

    // ---------------- behavioural model of instance 0 ----------------
    int m_h, m_m, m_s, m_ah, m_am, m_pc, m_left;
    int m_dh, m_dm, m_ds;
    bit m_tick, m_ring, m_pm;
    bit armed = 1'b0;
    int sh, sm, ss, tod;
    bit mt, trig, en;

    always @(posedge mclk) begin
        if (rst[0]) begin
            m_h = 0; m_m = 0; m_s = 0; m_ah = 0; m_am = 0; m_pc = 0; m_left = 0;
            m_dh = 0; m_dm = 0; m_ds = 0; m_tick = 0; m_ring = 0; m_pm = 0;
            armed = 1'b1;
        end else begin
            // display reflects the counters as they stood before this edge
            sh = (clk_mode == 2'd2) ? m_ah : m_h;
            sm = (clk_mode == 2'd2) ? m_am : m_m;
            ss = (clk_mode == 2'd2) ? 0 : m_s;
            m_dh = btn[3] ? ((sh % 12 == 0) ? 12 : sh % 12) : sh;
            m_pm = btn[3] && (sh >= 12);
            m_dm = sm;
            m_ds = ss;

            mt = (clk_mode != 2'd1) && (m_pc == DIV - 1);
            m_pc = (clk_mode == 2'd1 || mt) ? 0 : m_pc + 1;
            if (mt) begin
                tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = tod / 3600;
                m_m = (tod / 60) % 60;
                m_s = tod % 60;
            end

            en = (timer_mode == 2'd0);
            if (en && clk_mode == 2'd1) begin
                if (btn[0]) m_m = (m_m + 1) % 60;
                if (btn[1]) m_h = (m_h + 1) % 24;
                if (btn[2]) begin m_s = 0; m_pc = 0; end
            end

            trig = mt && alarm_en[0] && (m_h == m_ah) && (m_m == m_am) && (m_s == 0);

            if (en && clk_mode == 2'd2) begin
                if (btn[0]) m_am = (m_am + 1) % 60;
                if (btn[1]) m_ah = (m_ah + 1) % 24;
            end

            if (!alarm_en[0] || clk_mode == 2'd1) begin
                m_ring = 0;
            end else if (trig) begin
                m_ring = 1;
                m_left = RING0;
            end else if (m_ring && mt) begin
                m_left = m_left - 1;
                if (m_left == 0) m_ring = 0;
            end
            m_tick = mt;
        end
    end

    logic [47:0] act_v, exp_v;

    // Per-cycle comparison of instance 0 against the model.
    always @(negedge mclk) begin
        if (armed) begin
            act_v = {hours[0], minutes[0], seconds[0], alarm_hours[0], alarm_minutes[0],
                     tick_1hz[0], alarm_ring[0], disp_hours[0], disp_minutes[0],
                     disp_seconds[0], disp_pm[0]};
            exp_v = {5'(m_h), 6'(m_m), 6'(m_s), 5'(m_ah), 6'(m_am), m_tick, m_ring,
                     5'(m_dh), 6'(m_dm), 6'(m_ds), m_pm};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, act_v, exp_v);
            end
        end
        if (tick_1hz[0] === 1'b1) tick_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input int idx);
        btn[idx] = 1'b1;
        @(negedge mclk);
        btn[idx] = 1'b0;
        @(negedge mclk);
    endtask

    // Step hours to target with a final pulse, checking the display lag.
    task automatic hour_step(input int target, input int old_dh, input int old_pm,
                             input int new_dh, input int new_pm);
        for (int k = 0; k < 30 && cur_h != (target + 23) % 24; k++) begin
            pulse(1);
            cur_h = (cur_h + 1) % 24;
        end
        btn[1] = 1'b1;
        @(negedge mclk);
        btn[1] = 1'b0;
        cur_h = target;
        check($sformatf("h12_hours_%0d", target), int'(hours[0]), target);
        check($sformatf("h12_lag_dh_%0d", target), int'(disp_hours[0]), old_dh);
        check($sformatf("h12_lag_pm_%0d", target), int'(disp_pm[0]), old_pm);
        @(negedge mclk);
        check($sformatf("h12_dh_%0d", target), int'(disp_hours[0]), new_dh);
        check($sformatf("h12_pm_%0d", target), int'(disp_pm[0]), new_pm);
    endtask

    function automatic int all_out(input int g);
        return int'(|{hours[g], minutes[g], seconds[g], alarm_hours[g], alarm_minutes[g],
                      tick_1hz[g], alarm_ring[g], disp_hours[g], disp_minutes[g],
                      disp_seconds[g], disp_pm[g]});
    endfunction

    int nt;
    int len;

    initial begin
        rst = '1; clk_mode = 2'd0; timer_mode = 2'd0; btn = '0; alarm_en = '0; vb5 = 1'b0;
        repeat (3) @(negedge mclk);
        for (int g = 0; g < NDUT; g++) check($sformatf("reset_zero_%0d", g), all_out(g), 0);

        // lockout: pulses ignored while the timer owns the buttons
        rst = '0; clk_mode = 2'd1; timer_mode = 2'd1;
        repeat (3) pulse(0);
        repeat (2) pulse(1);
        timer_mode = 2'd0;
        @(negedge mclk);
        check("lockout_min", int'(minutes[0]), 0);
        check("lockout_hr", int'(hours[0]), 0);

        // set-time wrap, no carry, seconds frozen
        repeat (61) pulse(0);
        repeat (25) pulse(1);
        cur_h = 1;
        check("set_min", int'(minutes[0]), 1);
        check("set_hr", int'(hours[0]), 1);
        check("set_sec", int'(seconds[0]), 0);
        check("set_noticks", tick_cnt, 0);

        // 12h display
        btn[3] = 1'b1;
        @(negedge mclk);
        hour_step(0, 11, 1, 12, 0);
        hour_step(12, 11, 0, 12, 1);
        hour_step(13, 12, 1, 1, 1);

        // preload 23:59:00, alarm 00:00 enabled on instances 0..2
        repeat (10) pulse(1);
        cur_h = 23;
        repeat (58) pulse(0);
        alarm_en = 4'b0111;
        clk_mode = 2'd0;
        repeat (58 * DIV) @(negedge mclk);
        check("pre_hr", int'(hours[0]), 23);
        check("pre_min", int'(minutes[0]), 59);
        check("pre_sec", int'(seconds[0]), 58);

        nt = 0;
        for (int i = 1; i <= 2 * DIV; i++) begin
            @(negedge mclk);
            if (tick_1hz[0] === 1'b1) nt++;
            if (i == 2 * DIV - 1) begin
                check("ring_before_match", int'(alarm_ring[0]), 0);
                check("sec_before_match", int'(seconds[0]), 59);
            end
        end
        check("roll_ticks", nt, 2);
        check("roll_hr", int'(hours[0]), 0);
        check("roll_min", int'(minutes[0]), 0);
        check("roll_sec", int'(seconds[0]), 0);
        check("ring_rise_0", int'(alarm_ring[0]), 1);
        check("ring_rise_1", int'(alarm_ring[1]), 1);
        check("ring_rise_2", int'(alarm_ring[2]), 1);
        check("ring_disabled_3", int'(alarm_ring[3]), 0);

        // cancel on instance 1, reset mid-ring on instance 2
        alarm_en[1] = 1'b0;
        rst[2] = 1'b1;
        @(negedge mclk);
        check("ring_cancel_1", int'(alarm_ring[1]), 0);
        check("ring_hold_0", int'(alarm_ring[0]), 1);
        check("rst_mid_ring_2", all_out(2), 0);
        rst[2] = 1'b0;

        // ring on instance 0 ends after RING0 ticks
        repeat (RING0 * DIV - 2) @(negedge mclk);
        check("ring_last_cycle", int'(alarm_ring[0]), 1);
        @(negedge mclk);
        check("ring_fall", int'(alarm_ring[0]), 0);
        check("ring_fall_sec", int'(seconds[0]), RING0);

        // alarm set mode: seconds-clear ignored, display shows alarm
        clk_mode = 2'd2;
        pulse(0);
        repeat (25) pulse(1);
        pulse(2);
        check("alm_min", int'(alarm_minutes[0]), 1);
        check("alm_hr", int'(alarm_hours[0]), 1);
        check("alm_sec_kept", int'(seconds[0]), RING0);
        check("alm_disp_h", int'(disp_hours[0]), 1);
        check("alm_disp_m", int'(disp_minutes[0]), 1);
        check("alm_disp_s", int'(disp_seconds[0]), 0);

        // randomized phase against the model
        for (int seg = 0; seg < 12; seg++) begin
            clk_mode = 2'($urandom_range(0, 3));
            timer_mode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            btn[3] = 1'($urandom_range(0, 1));
            len = int'($urandom_range(300, 800));
            for (int c = 0; c < len; c++) begin
                @(negedge mclk);
                btn[0] = ($urandom_range(0, 9) == 0);
                btn[1] = ($urandom_range(0, 9) == 0);
                btn[2] = ($urandom_range(0, 29) == 0);
                alarm_en[0] = ($urandom_range(0, 19) != 0);
                vb5 = 1'($urandom_range(0, 1));
                rst[0] = ($urandom_range(0, 1999) == 0);
            end
        end
        rst[0] = 1'b0;
        repeat (3) @(negedge mclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
